// File: rtl/oifs_tx_fifo_pkg.sv
// Shared oifs tx datapath definitions: default payload width and channel encoding.
// Used by the tx interface, the tx controller and the tx FIFO.
package oifs_tx_fifo_pkg;

    localparam int OIFS_DATA_W_DEFAULT = 8;

    localparam logic OIFS_CH_A = 1'b0;
    localparam logic OIFS_CH_B = 1'b1;

endpackage

// File: rtl/oifs_tx_fifo_ram.sv
// Storage array for the oifs tx FIFO: synchronous write, asynchronous read.
module oifs_tx_fifo_ram #(
    parameter int WIDTH      = 9,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // NOTE: storage is deliberately left out of reset; the pointers alone decide
    // which entries are valid, and this keeps the array mappable to RAM cells.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/oifs_tx_fifo.sv
// First-word-fall-through FIFO between the oifs tx controller and the tx interface.
// Each entry carries one payload byte plus its channel bit; ordering is never changed.
module oifs_tx_fifo
    import oifs_tx_fifo_pkg::*;
#(
    parameter int DATA_W     = OIFS_DATA_W_DEFAULT,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                i_clk,
    input  logic                i_arst,
    input  logic                i_valid,
    input  logic [DATA_W-1:0]   i_data,
    input  logic                i_channel,
    output logic                o_ready,
    output logic                o_valid,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_channel,
    input  logic                i_ready,
    output logic [DEPTH_LOG2:0] o_level,
    output logic                o_empty,
    output logic                o_full
);

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                push;
    logic                pop;
    logic [DATA_W:0]     head;

    // Flags come only from the registered pointers, so o_ready has no path from i_ready/i_valid.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign o_level = wr_ptr - rd_ptr;

    assign o_ready = !o_full;
    assign o_valid = !o_empty;

    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    oifs_tx_fifo_ram #(
        .WIDTH      (DATA_W + 1),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (i_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data ({i_channel, i_data}),
        .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
        .rd_data (head)
    );

    assign o_data    = head[DATA_W-1:0];
    assign o_channel = head[DATA_W];

endmodule

// File: doc/oifs_tx_fifo.md
OIFS_TX_FIFO -- requirements
Module: oifs_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8: payload byte width.
REQ-002 Parameter DEPTH_LOG2, default 4: storage depth is 2**DEPTH_LOG2 entries, legal range 1..8.
REQ-003 i_clk  input  1  system clock; all state updates on rising edge.
REQ-004 i_arst  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  upstream word valid.
REQ-006 i_data  input  DATA_W  upstream payload byte.
REQ-007 i_channel  input  1  upstream channel select (0 = channel A, 1 = channel B).
REQ-008 o_ready  output  1  FIFO can accept a word this cycle.
REQ-009 o_valid  output  1  head word valid toward the oifs tx interface.
REQ-010 o_data  output  DATA_W  head payload byte.
REQ-011 o_channel  output  1  head channel bit.
REQ-012 i_ready  input  1  oifs tx interface accepts the head word.
REQ-013 o_level  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
REQ-014 o_empty / o_full  output  1 each  occupancy == 0 / occupancy == 2**DEPTH_LOG2.

Function
REQ-015 Push occurs on a rising edge where i_valid && o_ready; {i_channel, i_data} is stored as one entry.
REQ-016 Pop occurs on a rising edge where o_valid && i_ready; the head entry is discarded.
REQ-017 o_valid = !o_empty; o_data/o_channel present the oldest stored entry (first-word-fall-through).
REQ-018 Latency: a word pushed at edge N into an empty FIFO is presented with o_valid=1 after edge N, with no bubble.
REQ-019 o_ready = !o_full, derived from registered state only; no combinational path from i_ready or i_valid to o_ready.
REQ-020 When full, a push is refused even if a pop occurs in the same cycle.
REQ-021 Simultaneous push and pop when not full and not empty: level unchanged, both pointers advance.
REQ-022 Push with no pop: level +1. Pop with no push: level -1.
REQ-023 Write and read pointers are DEPTH_LOG2+1 bits wide and wrap modulo 2**(DEPTH_LOG2+1).
REQ-024 Empty is defined as pointers equal. Full is defined as the MSBs differing and the lower bits equal.
REQ-025 o_level = wr_ptr - rd_ptr, computed modulo 2**(DEPTH_LOG2+1), and is always consistent with o_empty/o_full.
REQ-026 o_data/o_channel hold stable while o_valid=1 and i_ready=0.
REQ-027 Data contents are don't-care while o_valid=0.
REQ-028 Entry order is preserved across channels; the FIFO never reorders or drops accepted words.

Reset
REQ-029 While i_arst=1, pointers = 0, o_empty=1, o_full=0, o_valid=0, o_ready=1, o_level=0.
REQ-030 Reset asserted mid-operation discards all stored entries immediately; storage array contents are not reset.
REQ-031 The first push is accepted on the first rising edge after i_arst deasserts.

Structure
REQ-032 Shared oifs definitions include file holds DATA_W default and the channel encoding constants OIFS_CH_A=0, OIFS_CH_B=1, common to the tx interface, tx controller and this block.
REQ-033 Storage is one sub-module oifs_tx_fifo_ram: width DATA_W+1, depth 2**DEPTH_LOG2, synchronous write, asynchronous read.
REQ-034 Pointer, flag and level logic reside in oifs_tx_fifo.
REQ-035 The block sits between oifs_tx_controller and oifs_tx_interface in the tx datapath simulation top.

Verification
REQ-036 Scenario: after reset, push 0xA5/ch0 with i_ready=0 -> next cycle o_valid=1, o_data=0xA5, o_channel=0, o_level=1.
REQ-037 Scenario: DEPTH_LOG2=2, push 0x01..0x04 with i_ready=0 -> o_full=1, o_ready=0, o_level=4; a fifth push is ignored and the head remains 0x01.
REQ-038 Scenario: full FIFO with i_valid=1 and i_ready=1 -> pop only, o_level=3, pushed word not stored; the next cycle o_ready=1.
REQ-039 Scenario: stream 40 words with alternating channels through DEPTH_LOG2=2 while i_ready toggles every 3 cycles -> output sequence and channel bits identical to input, and no word lost across pointer wrap.
REQ-040 Scenario: simultaneous push/pop at level 2 -> o_level stays 2 and the head advances to the next word.
REQ-041 Scenario: assert i_arst for one cycle with o_level=3 -> o_valid=0, o_level=0, o_ready=1 immediately; a later push of 0x5A is output as the first word.
